alu5_seq_ctrl: RTL
==================

Name: alu5_seq_ctrl

Overview:
Command sequencer for the shared 5-bit signed add/subtract datapath: add, subtract, absolute sum, signed less-than and a multi-cycle multiply. Accepts one command at a time over a valid/ready handshake and drives a single time-shared adder over one or more cycles. Returns a registered response over a second valid/ready handshake. Sits between a command source (test controller or host FSM) and the arithmetic datapath.

Parameters:
W, 5, operand/result width in bits (two's complement); all values below assume W=5
CNT_W, 8, width of the completed-command counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  3  000 ADD, 001 SUB, 010 ABS, 011 LT, 100 MUL, 101-111 illegal
cmd_a  in  W  operand A, signed
cmd_b  in  W  operand B, signed
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  W  result
rsp_of  out  1  signed overflow / unrepresentable result
rsp_lt  out  1  A<B (LT only, else 0)
rsp_err  out  1  illegal opcode
busy  out  1  state != IDLE
op_count  out  CNT_W  completed responses, wraps

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; cmd_ready, rsp_valid, rsp_result, rsp_of, rsp_lt, rsp_err, busy, op_count all 0; any in-flight command is discarded. cmd_ready rises on the first clk edge after rst_n deasserts.
- States: IDLE, EXEC, FIX, MUL, RESP.
- cmd_ready=1 only in IDLE, registered; no accept while busy or while a response is pending.
- Accept on the edge where cmd_valid&cmd_ready. cmd_op, cmd_a and cmd_b are captured; later input changes are ignored. Next state: MUL for op 100, otherwise EXEC.
- EXEC (1 cycle), one adder pass:
  - ADD: A+B. of = carry-into-MSB XOR carry-out.
  - SUB: A+~B+1. of set when sign(A)!=sign(B) and sign(result)!=sign(A).
  - LT: computes A-B. lt = diff[4] XOR of, so it is correct across overflow; result=0, of=0.
  - ABS: computes the sum. If sum[4]=1 go to FIX; else go to RESP with result=sum and of=sum-overflow.
  - Illegal: result=0, err=1.
  - All cases except negative ABS go to RESP.
- FIX (1 cycle, ABS only): result = ~sum+1 through the same adder. of = sum-overflow OR (sum==10000); a result of 10000 is returned as is.
- MUL: 10-bit accumulator cleared on entry. Iteration i=0..4, one per cycle: if B[i] is set, add sign-extended A<<i; i=4 subtracts instead (weight -16).
  - After 5 cycles: result = acc[4:0]; of=1 unless acc[9:4] is all 0s or all 1s.
- RESP: rsp_valid=1. All rsp_* fields are stable until the edge where rsp_valid&rsp_ready. On that edge: op_count+1 (wraps from 2^CNT_W-1 to 0), go to IDLE, rsp_valid drops, cmd_ready rises.
- Latency from accept edge to rsp_valid high: ADD/SUB/LT/illegal and non-negative ABS 2 cycles; negative ABS 3 cycles; MUL 6 cycles.
- Minimum spacing between accepts: latency+1 cycles (no accept/response overlap, no bypass).
- rsp_valid with rsp_ready already high completes in the first RESP cycle.
- The datapath adder is used only in EXEC, FIX and MUL; exactly one pass per cycle.

Test Plan:
- ADD 7+8 -> result 01111, of=0, rsp_valid 2 cycles after accept. ADD 8+8 -> 10000, of=1. ADD -16+-1 -> 01111, of=1.
- SUB -16-1 -> 01111, of=1. LT A=-16, B=1 -> lt=1, result 00000 (diff sign alone gives 0). LT A=3, B=3 -> lt=0.
- ABS A=-3, B=-4 -> 00111, of=0, latency 3. ABS -8+-8 -> 10000, of=1. ABS 2+3 -> 00101, latency 2.
- MUL 3*-5 -> 10001 (-15), of=0, latency 6. MUL -16*-1 -> 10000, of=1. MUL 5*5 -> 11001, of=1. MUL 0*-16 -> 00000, of=0.
- Backpressure: hold rsp_ready=0 for 4 cycles after rsp_valid while toggling cmd_valid with new operands -> rsp fields stable, cmd_ready=0, no second accept. On release, op_count increments by 1 and the next command is accepted one cycle later. Op 110 -> err=1, result 0. Issue 256 commands -> op_count wraps to 0.
- Reset in the 3rd MUL cycle -> all outputs 0 immediately with no clock. After release, cmd_ready=1 next edge; ADD 1+1 -> 00010 and op_count=1.

Source files
------------

// File: rtl/alu5_seq_ctrl.sv
// Command sequencer driving one shared add/sub datapath: ADD/SUB/LT/ABS/MUL with valid/ready on both sides.
// Latency 2 (neg ABS 3, MUL 6) cycles from accept; one command in flight, response held until rsp_ready.
module alu5_seq_ctrl #(
    parameter int W     = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_result,
    output logic             rsp_of,
    output logic             rsp_lt,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    localparam int AW = 2 * W;
    localparam int IW = $clog2(W + 1);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ABS = 3'b010;
    localparam logic [2:0] OP_LT  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_FIX, S_MUL, S_RESP} state_t;

    state_t           r_state, w_next;
    logic [2:0]       r_op;
    logic [W-1:0]     r_a, r_b, r_sum;
    logic             r_sum_of;
    logic [AW-1:0]    r_acc;
    logic [IW-1:0]    r_i;
    logic             r_cmd_ready, r_rsp_valid;
    logic [W-1:0]     r_result;
    logic             r_of, r_lt, r_err;
    logic [CNT_W-1:0] r_cnt;

    logic [AW-1:0]    w_x, w_y, w_s, w_sh;
    logic             w_cin, w_of5, w_bit, w_last, w_mul_of, w_accept;
    logic [AW-W:0]    w_top;

    assign w_accept = cmd_valid && r_cmd_ready;
    assign w_sh     = {{W{r_a[W-1]}}, r_a} << r_i;
    assign w_bit    = r_b[r_i];
    assign w_last   = (r_i == IW'(W - 1));

    // Single adder; narrow ops ride zero-extended in the low W bits so bit W is their carry-out.
    always_comb begin
        w_x   = '0;
        w_y   = '0;
        w_cin = 1'b0;
        case (r_state)
            S_EXEC: begin
                w_x = {{(AW-W){1'b0}}, r_a};
                if (r_op == OP_SUB || r_op == OP_LT) begin
                    w_y   = {{(AW-W){1'b0}}, ~r_b};
                    w_cin = 1'b1;
                end else begin
                    w_y = {{(AW-W){1'b0}}, r_b};
                end
            end
            S_FIX: begin
                w_x   = {{(AW-W){1'b0}}, ~r_sum};
                w_cin = 1'b1;
            end
            S_MUL: begin
                w_x = r_acc;
                if (w_bit) begin
                    // The sign bit of B carries negative weight, so that partial product is subtracted.
                    if (w_last) begin
                        w_y   = ~w_sh;
                        w_cin = 1'b1;
                    end else begin
                        w_y = w_sh;
                    end
                end
            end
            default: ;
        endcase
        w_s = w_x + w_y + {{(AW-1){1'b0}}, w_cin};
    end

    assign w_of5    = w_x[W-1] ^ w_y[W-1] ^ w_s[W-1] ^ w_s[W];
    assign w_top    = w_s[AW-1:W-1];
    assign w_mul_of = ~((&w_top) | ~(|w_top));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = (cmd_op == OP_MUL) ? S_MUL : S_EXEC;
            S_EXEC: w_next = (r_op == OP_ABS && w_s[W-1]) ? S_FIX : S_RESP;
            S_FIX:  w_next = S_RESP;
            S_MUL:  if (w_last) w_next = S_RESP;
            S_RESP: if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_sum_of    <= 1'b0;
            r_acc       <= '0;
            r_i         <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_result    <= '0;
            r_of        <= 1'b0;
            r_lt        <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == S_IDLE);
            r_rsp_valid <= (w_next == S_RESP);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= cmd_op;
                        r_a   <= cmd_a;
                        r_b   <= cmd_b;
                        r_acc <= '0;
                        r_i   <= '0;
                    end
                end
                S_EXEC: begin
                    r_sum    <= w_s[W-1:0];
                    r_sum_of <= w_of5;
                    r_result <= '0;
                    r_of     <= 1'b0;
                    r_lt     <= 1'b0;
                    r_err    <= 1'b0;
                    case (r_op)
                        OP_ADD, OP_SUB, OP_ABS: begin
                            r_result <= w_s[W-1:0];
                            r_of     <= w_of5;
                        end
                        OP_LT:   r_lt  <= w_s[W-1] ^ w_of5;
                        default: r_err <= 1'b1;
                    endcase
                end
                S_FIX: begin
                    r_result <= w_s[W-1:0];
                    r_of     <= r_sum_of | (r_sum == MIN_NEG);
                end
                S_MUL: begin
                    r_acc <= w_s;
                    r_i   <= r_i + 1'b1;
                    if (w_last) begin
                        r_result <= w_s[W-1:0];
                        r_of     <= w_mul_of;
                        r_lt     <= 1'b0;
                        r_err    <= 1'b0;
                    end
                end
                S_RESP: if (rsp_ready) r_cnt <= r_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_result;
    assign rsp_of     = r_of;
    assign rsp_lt     = r_lt;
    assign rsp_err    = r_err;
    assign busy       = (r_state != S_IDLE);
    assign op_count   = r_cnt;
endmodule
